ch_mem_arbiter: RTL and testbench

- Controller that shares the cluster-head memory bank between two requesters.
  - Requester 0 is the packet handler (stores CH IDs and fitness values).
  - Requester 1 is the Q-learning update engine (reads and writes Q-values).
- Drives the bank's single write-enable/index/data port with two-to-one round-robin arbitration.
- Registers bank read data back to the winning requester.
- Also sequences a full-bank clear sweep on command. Sits between the requesters and the bank.

---
 rtl/ch_mem_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/ch_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ch_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_mem_pkg.sv
// Shared constants, FSM state type and address legality helper for the
// cluster-head memory arbiter.
package ch_mem_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned MEM_DEPTH  = 32;
    localparam int unsigned CH_WORDS   = MEM_DEPTH / 2;
    localparam int unsigned CNT_W      = $clog2(CH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CLEAR
    } state_t;

    // A word access must start on an even byte and fit inside the bank.
    function automatic logic addr_illegal(logic [WORD_WIDTH-1:0] addr);
        return addr[0] | (addr > WORD_WIDTH'(MEM_DEPTH - 2));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer lives here and is
// advanced only when the caller commits a grant via update.
module rr_arb2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req0,
    input  logic       req1,
    input  logic       update,
    output logic [1:0] winner
);

    logic r_last;

    // On a conflict, favour the requester that was not granted last.
    always_comb begin
        winner    = 2'b00;
        winner[0] = req0 & (~req1 | r_last);
        winner[1] = req1 & (~req0 | ~r_last);
    end

    // Pointer starts at 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last <= 1'b1;
        end else if (update) begin
            r_last <= winner[1];
        end
    end

endmodule

// File: rtl/ch_mem_arbiter.sv
// Shares the cluster-head memory bank between the packet handler (req 0) and
// the Q-learning engine (req 1), and sequences a whole-bank zero sweep.
// Optional build macro CH_MEM_ADDR_CHECK_EN adds illegal-address suppression
// and the addr_err output.
module ch_mem_arbiter
    import ch_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [WORD_WIDTH-1:0] addr0,
    input  logic [WORD_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0] wdata0,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [WORD_WIDTH-1:0] rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  bank_wr_en,
    output logic [WORD_WIDTH-1:0] bank_index,
    output logic [WORD_WIDTH-1:0] bank_data_in,
    input  logic [WORD_WIDTH-1:0] bank_data_out
`ifdef CH_MEM_ADDR_CHECK_EN
    ,
    output logic                  addr_err
`endif
);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_id;
    logic                  r_we;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_clr_done;
    logic                  w_arb_update;
    logic [1:0]            w_winner;
    logic                  w_sweep_last;
    logic                  w_addr_ok;

    assign w_arb_update = (r_state == IDLE) & ~clr_start & (req0 | req1);
    assign w_sweep_last = (r_cnt == CNT_W'(CH_WORDS - 1));

`ifdef CH_MEM_ADDR_CHECK_EN
    logic r_err;
    assign w_addr_ok = ~r_err;
    assign addr_err  = (r_state == ACCESS) & r_err;

    // Legality is judged on the request that wins arbitration.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_err <= 1'b0;
        end else if (w_arb_update) begin
            r_err <= addr_illegal(w_winner[1] ? addr1 : addr0);
        end
    end
`else
    assign w_addr_ok = 1'b1;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .nrst   (nrst),
        .req0   (req0),
        .req1   (req1),
        .update (w_arb_update),
        .winner (w_winner)
    );

    // Next-state: the sweep beats requests in IDLE; ACCESS lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (clr_start) begin
                    w_next_state = CLEAR;
                end else if (req0 | req1) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS:  w_next_state = IDLE;
            CLEAR:   if (w_sweep_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Bank port and grant decode from registered state only.
    always_comb begin
        bank_wr_en   = 1'b0;
        bank_index   = '0;
        bank_data_in = '0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        case (r_state)
            ACCESS: begin
                bank_wr_en   = r_we & w_addr_ok;
                bank_index   = w_addr_ok ? r_addr : '0;
                bank_data_in = r_wdata;
                gnt0         = ~r_id;
                gnt1         = r_id;
            end
            CLEAR: begin
                bank_wr_en = 1'b1;
                bank_index = WORD_WIDTH'({r_cnt, 1'b0});
            end
            default: ;
        endcase
    end

    assign clr_busy = (r_state == CLEAR);
    assign clr_done = r_clr_done;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = r_rdata;

    // State, sweep counter, captured request and read-return registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rvalid0  <= (r_state == ACCESS) & ~r_we & ~r_id;
            r_rvalid1  <= (r_state == ACCESS) & ~r_we & r_id;
            r_clr_done <= (r_state == CLEAR) & w_sweep_last;
            if ((r_state == IDLE) && clr_start) begin
                r_cnt <= '0;
            end else if ((r_state == CLEAR) && !w_sweep_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_arb_update) begin
                r_id    <= w_winner[1];
                r_we    <= w_winner[1] ? we1 : we0;
                r_addr  <= w_winner[1] ? addr1 : addr0;
                r_wdata <= w_winner[1] ? wdata1 : wdata0;
            end
            if ((r_state == ACCESS) && !r_we) begin
                r_rdata <= w_addr_ok ? bank_data_out : '0;
            end
        end
    end

endmodule

// File: tb/tb_ch_mem_arbiter.sv
// Self-checking bench for ch_mem_arbiter: directed scenarios plus a
// randomized two-requester phase checked against a word-level model.
module tb_ch_mem_arbiter;
    import ch_mem_pkg::*;

    logic        clk;
    logic        nrst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        clr_start, clr_busy, clr_done;
    logic        bank_wr_en;
    logic [15:0] bank_index, bank_data_in, bank_data_out;
`ifdef CH_MEM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  bank_mem [MEM_DEPTH];
    logic [15:0] exp_words [CH_WORDS];

    ch_mem_arbiter dut (
        .clk           (clk),
        .nrst          (nrst),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rvalid0       (rvalid0),
        .rvalid1       (rvalid1),
        .rdata         (rdata),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .clr_done      (clr_done),
        .bank_wr_en    (bank_wr_en),
        .bank_index    (bank_index),
        .bank_data_in  (bank_data_in),
        .bank_data_out (bank_data_out)
`ifdef CH_MEM_ADDR_CHECK_EN
        ,
        .addr_err      (addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed bank, big-endian word at index / index+1.
    always_comb begin
        bank_data_out = '0;
        if (int'(bank_index) < int'(MEM_DEPTH) - 1)
            bank_data_out = {bank_mem[int'(bank_index)], bank_mem[int'(bank_index) + 1]};
    end

    always @(posedge clk) begin
        if (bank_wr_en && int'(bank_index) < int'(MEM_DEPTH) - 1) begin
            bank_mem[int'(bank_index)]     <= bank_data_in[15:8];
            bank_mem[int'(bank_index) + 1] <= bank_data_in[7:0];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from requester id; returns read data and req-to-gnt latency.
    task automatic do_access(input bit id, input bit we, input logic [15:0] addr,
                             input logic [15:0] wd, output logic [15:0] rd, output int lat);
        bit got;
        rd  = '0;
        lat = 0;
        got = 1'b0;
        if (!id) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
        end
        while (!got && lat < 20) begin
            tick();
            lat++;
            got = id ? gnt1 : gnt0;
        end
        check_eq("gnt_seen", 32'(got), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!we && got) begin
            tick();
            check_eq(id ? "rvalid1" : "rvalid0", 32'(id ? rvalid1 : rvalid0), 32'd1);
            rd = rdata;
        end
    endtask

    task automatic wr_word(input bit id, input int w, input logic [15:0] d);
        logic [15:0] rd;
        int lat;
        do_access(id, 1'b1, 16'(2 * w), d, rd, lat);
        exp_words[w] = d;
    endtask

    task automatic rd_check(input bit id, input int w);
        logic [15:0] rd;
        int lat;
        do_access(id, 1'b0, 16'(2 * w), 16'h0, rd, lat);
        check_eq("word_read", 32'(rd), 32'(exp_words[w]));
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        bit          found;
        bit          pend [2];
        bit          p_we [2];
        logic [15:0] p_addr [2];
        logic [15:0] p_wd [2];
        bit          m_avail, m_last;
        bit          nrv [2];
        bit          erv [2];
        bit          eg [2];
        logic [15:0] nrd, erd;
        int          w;

        nrst = 1'b0; clr_start = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset state with both requests already pending.
        repeat (3) tick();
        check_eq("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check_eq("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_clr", 32'({clr_busy, clr_done}), 32'd0);
        check_eq("rst_bank_we", 32'(bank_wr_en), 32'd0);
        check_eq("rst_bank_idx", 32'(bank_index), 32'd0);
        check_eq("rst_bank_din", 32'(bank_data_in), 32'd0);

        // Both held from reset: 0,1,0,1 grants every second cycle.
        nrst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_eq("rr_gnt0", 32'(gnt0), 32'(c % 4 == 1));
            check_eq("rr_gnt1", 32'(gnt1), 32'(c % 4 == 3));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // Write via requester 0, read back via requester 1.
        do_access(1'b0, 1'b1, 16'd4, 16'hA55A, rd, lat);
        check_eq("wr_latency", 32'(lat), 32'd1);
        tick();
        check_eq("bank_byte4", 32'(bank_mem[4]), 32'hA5);
        check_eq("bank_byte5", 32'(bank_mem[5]), 32'h5A);
        do_access(1'b1, 1'b0, 16'd4, 16'h0, rd, lat);
        check_eq("rd_latency", 32'(lat), 32'd1);
        check_eq("rd_data", 32'(rd), 32'hA55A);
        tick();

        // Fill, then sweep with a request raised part-way through.
        for (int i = 0; i < int'(CH_WORDS); i++) wr_word(1'b0, i, 16'hFFFF);
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < int'(CH_WORDS); k++) begin
            check_eq("sweep_busy", 32'(clr_busy), 32'd1);
            check_eq("sweep_we", 32'(bank_wr_en), 32'd1);
            check_eq("sweep_index", 32'(bank_index), 32'(2 * k));
            check_eq("sweep_data", 32'(bank_data_in), 32'd0);
            check_eq("sweep_no_gnt", 32'({gnt0, gnt1, clr_done}), 32'd0);
            if (k == 3) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = 16'd10;
            end
            tick();
        end
        for (int i = 0; i < int'(CH_WORDS); i++) exp_words[i] = 16'h0000;
        check_eq("clr_done", 32'(clr_done), 32'd1);
        check_eq("clr_busy_drop", 32'(clr_busy), 32'd0);
        check_eq("done_no_gnt", 32'(gnt0), 32'd0);
        tick();
        check_eq("gnt_after_clr", 32'(gnt0), 32'd1);
        check_eq("clr_done_pulse", 32'(clr_done), 32'd0);
        req0 = 1'b0;
        tick();
        check_eq("rvalid_after_clr", 32'(rvalid0), 32'd1);
        check_eq("rdata_after_clr", 32'(rdata), 32'd0);
        for (int i = 0; i < int'(CH_WORDS); i++) rd_check(1'(i % 2), i);

        // Reset in the middle of a sweep (k = 7).
        for (int i = 0; i < int'(CH_WORDS); i++) wr_word(1'b1, i, 16'hFFFF);
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (clr_busy && bank_index == 16'd14) found = 1'b1;
            else tick();
        end
        check_eq("sweep_k7_reached", 32'(found), 32'd1);
        nrst = 1'b0;
        #1;
        check_eq("rst_mid_we", 32'(bank_wr_en), 32'd0);
        check_eq("rst_mid_busy", 32'(clr_busy), 32'd0);
        check_eq("rst_mid_rdata", 32'(rdata), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) nrst = 1'b1;
            tick();
            check_eq("rst_mid_no_done", 32'(clr_done), 32'd0);
        end
        for (int i = 0; i < 7; i++) exp_words[i] = 16'h0000;
        for (int i = 0; i < int'(CH_WORDS); i++) rd_check(1'(i % 2), i);

        // Randomized two-requester traffic against a word-level model.
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        m_avail = 1'b1; m_last = 1'b1;
        nrv = '{1'b0, 1'b0}; nrd = '0;
        pend = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            erv = nrv; erd = nrd;
            nrv = '{1'b0, 1'b0};
            eg = '{1'b0, 1'b0};
            if (m_avail && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
                eg[w] = 1'b1;
                m_last = (w == 1);
                m_avail = 1'b0;
                if (p_we[w]) exp_words[int'(p_addr[w]) / 2] = p_wd[w];
                else begin
                    nrv[w] = 1'b1;
                    nrd = exp_words[int'(p_addr[w]) / 2];
                end
            end else begin
                m_avail = 1'b1;
            end
            check_eq("rnd_gnt0", 32'(gnt0), 32'(eg[0]));
            check_eq("rnd_gnt1", 32'(gnt1), 32'(eg[1]));
            check_eq("rnd_rvalid0", 32'(rvalid0), 32'(erv[0]));
            check_eq("rnd_rvalid1", 32'(rvalid1), 32'(erv[1]));
            if (erv[0] || erv[1]) check_eq("rnd_rdata", 32'(rdata), 32'(erd));
            for (int i = 0; i < 2; i++) begin
                if (eg[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    p_we[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = 16'(2 * $urandom_range(0, int'(CH_WORDS) - 1));
                    p_wd[i]   = 16'($urandom);
                end
            end
            req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
            req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < int'(CH_WORDS); i++) rd_check(1'(i % 2), i);

`ifdef CH_MEM_ADDR_CHECK_EN
        // Illegal odd / out-of-range accesses are granted but suppressed.
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd31; wdata0 = 16'h1234;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = gnt0;
        end
        check_eq("ill_wr_gnt", 32'(found), 32'd1);
        check_eq("ill_wr_err", 32'(addr_err), 32'd1);
        check_eq("ill_wr_we", 32'(bank_wr_en), 32'd0);
        check_eq("ill_wr_idx", 32'(bank_index), 32'd0);
        req0 = 1'b0;
        tick();
        check_eq("ill_err_pulse", 32'(addr_err), 32'd0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = gnt1;
        end
        check_eq("ill_rd_gnt", 32'(found), 32'd1);
        check_eq("ill_rd_err", 32'(addr_err), 32'd1);
        req1 = 1'b0;
        tick();
        check_eq("ill_rd_rvalid", 32'(rvalid1), 32'd1);
        check_eq("ill_rd_data", 32'(rdata), 32'd0);
        for (int i = 0; i < int'(CH_WORDS); i++) rd_check(1'(i % 2), i);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
